// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter.
// Bytes written with transmit/tx_byte are queued in a small FIFO and sent
// LSB first as start + 8 data + optional parity + 1 or 2 stop bits.
// Back-to-back frames leave no idle gap on the line, and every output is registered.

module uart_tx_fifo #(
  parameter int baud_rate    = 9600,
  parameter int sys_clk_freq = 100000000,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          transmit,
  input  logic [7:0]                    tx_byte,
  output logic                          tx,
  output logic                          is_transmitting,
  output logic                          tx_full,
  output logic                          tx_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  // Bit timing. The stop phase is timed as a single long interval, so the
  // baud counter is sized for the longest phase.
  localparam int CLKS_PER_BIT = sys_clk_freq / baud_rate;
  localparam int STOP_CLKS    = STOP_BITS * CLKS_PER_BIT;
  localparam int CNT_W        = $clog2(STOP_CLKS);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int CW           = PTR_W + 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);
  localparam logic [CW-1:0]    DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CW-1:0]    count_next;
  logic [7:0]       head_byte;
  logic             push;
  logic             pop;

  // Serialiser state
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] baud_cnt;
  logic [CNT_W-1:0] baud_next;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_next;
  logic [7:0]       shift_reg;
  logic [7:0]       shift_next;
  logic             par_bit;
  logic             par_next;
  logic             tx_next;
  logic             busy_next;

  // A write is taken only when the FIFO is not full; a pop in the same
  // cycle does not make room for it, because tx_full is the registered flag.
  assign push      = transmit & ~tx_full;
  assign head_byte = mem[rd_ptr];

  // Next occupancy from the push/pop pair; simultaneous push and pop cancel.
  always_comb begin
    count_next = fifo_count;
    if (push && !pop) begin
      count_next = fifo_count + CW'(1);
    end else if (!push && pop) begin
      count_next = fifo_count - CW'(1);
    end
  end

  // Byte storage: data is captured only at the accepting edge.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_byte;
    end
  end

  // FIFO pointers, occupancy, status flags and the sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      tx_full    <= 1'b0;
      tx_empty   <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      fifo_count <= count_next;
      tx_full    <= (count_next == DEPTH_C);
      tx_empty   <= (count_next == '0);
      if (transmit && tx_full) begin
        overflow <= 1'b1;
      end
    end
  end

  // State register, together with the bit-timing datapath and registered line outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      baud_cnt        <= '0;
      bit_idx         <= '0;
      shift_reg       <= '0;
      par_bit         <= 1'b0;
      tx              <= 1'b1;
      is_transmitting <= 1'b0;
    end else begin
      state           <= state_next;
      baud_cnt        <= baud_next;
      bit_idx         <= bit_next;
      shift_reg       <= shift_next;
      par_bit         <= par_next;
      tx              <= tx_next;
      is_transmitting <= busy_next;
    end
  end

  // Next-state logic: the baud counter restarts at every bit boundary. The head
  // byte is popped either from IDLE or at the final stop-bit edge, which lets
  // frames run back to back.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt + CNT_W'(1);
    bit_next   = bit_idx;
    shift_next = shift_reg;
    par_next   = par_bit;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        baud_next = '0;
        if (!tx_empty) begin
          pop        = 1'b1;
          shift_next = head_byte;
          par_next   = (PARITY == 2) ? ~^head_byte : ^head_byte;
          state_next = START;
        end
      end
      START: begin
        if (baud_cnt == BIT_LAST) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (baud_cnt == BIT_LAST) begin
          baud_next  = '0;
          shift_next = {1'b0, shift_reg[7:1]};
          if (bit_idx == 3'd7) begin
            state_next = (PARITY != 0) ? PAR : STOP;
          end else begin
            bit_next = bit_idx + 3'd1;
          end
        end
      end
      PAR: begin
        if (baud_cnt == BIT_LAST) begin
          baud_next  = '0;
          state_next = STOP;
        end
      end
      STOP: begin
        if (baud_cnt == STOP_LAST) begin
          baud_next = '0;
          if (!tx_empty) begin
            pop        = 1'b1;
            shift_next = head_byte;
            par_next   = (PARITY == 2) ? ~^head_byte : ^head_byte;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        baud_next  = '0;
        state_next = IDLE;
      end
    endcase
  end

  // Output logic: the line level and busy flag for the upcoming state are
  // registered, so tx changes on the same edge the state changes.
  always_comb begin
    tx_next   = 1'b1;
    busy_next = (state_next != IDLE);
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PAR:     tx_next = par_next;
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: three transmitter instances (no parity / 1 stop,
// even parity / 2 stop, odd parity / 1 stop) share one stimulus stream.
// Each lane has a queue-based reference model that predicts FIFO contents and
// frame start times, plus a line monitor that decodes frames against the expected ones.

module tb_uart_tx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [7:0] b;
    int         start;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       transmit = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       fin = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  logic [2:0]    tx_v;
  logic [2:0]    busy_v;
  logic [2:0]    full_v;
  logic [2:0]    empty_v;
  logic [2:0]    ovf_v;
  logic [CW-1:0] cnt_v [3];

  // Free-running clock and a cycle counter that equals the index of the last rising edge.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point: every check is counted here, and every miss is reported.
  task automatic checkOutput(input string name, input int lane,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s lane %0d: got %0h, expected %0h (cycle %0d)",
               name, lane, act, exp, cyc);
    end
  endtask

  // One write strobe, then the byte bus is scrambled and the bench idles gap cycles.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    transmit = 1'b1;
    tx_byte  = b;
    @(negedge clk);
    transmit = 1'b0;
    tx_byte  = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  // Bounded wait until every lane has drained its FIFO and left the line idle.
  task automatic waitIdle(input int limit);
    int n;
    n = 0;
    while (!(busy_v == 3'b000 && empty_v == 3'b111) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_timeout: still busy after %0d cycles, required idle", n);
    end
    repeat (3) @(negedge clk);
  endtask

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int PAR   = (g == 1) ? 1 : ((g == 2) ? 2 : 0);
    localparam int STP   = (g == 1) ? 2 : 1;
    localparam int NSLOT = 10 + ((PAR != 0) ? 1 : 0);
    localparam int FRAME = (10 + ((PAR != 0) ? 1 : 0) + STP - 1) * CPB;

    logic [7:0] q[$];
    frame_t     exp_q[$];
    int         free_at = 0;
    logic       m_ovf = 1'b0;
    int         m_e;
    int         m_n;
    frame_t     m_f;

    uart_tx_fifo #(
      .baud_rate   (10),
      .sys_clk_freq(160),
      .FIFO_DEPTH  (DEPTH),
      .PARITY      (PAR),
      .STOP_BITS   (STP)
    ) dut (
      .clk            (clk),
      .rst            (rst),
      .transmit       (transmit),
      .tx_byte        (tx_byte),
      .tx             (tx_v[g]),
      .is_transmitting(busy_v[g]),
      .tx_full        (full_v[g]),
      .tx_empty       (empty_v[g]),
      .fifo_count     (cnt_v[g]),
      .overflow       (ovf_v[g])
    );

    // Reference model: a byte queue plus the edge from which the transmitter
    // may take the next byte. Each take schedules one expected frame.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        q.delete();
        exp_q.delete();
        free_at = 0;
        m_ovf   = 1'b0;
      end else begin
        m_e = cyc + 1;
        m_n = q.size();
        if (m_n > 0 && m_e >= free_at) begin
          m_f.b     = q.pop_front();
          m_f.start = m_e;
          exp_q.push_back(m_f);
          free_at = m_e + FRAME;
        end
        if (transmit) begin
          if (m_n == DEPTH) m_ovf = 1'b1;
          else q.push_back(tx_byte);
        end
      end
    end

    // Status outputs compared with the model every cycle, away from the clock edge.
    always @(negedge clk) begin
      checkOutput("fifo_count", g, 32'(cnt_v[g]), q.size());
      checkOutput("tx_full", g, 32'(full_v[g]), 32'(q.size() == DEPTH));
      checkOutput("tx_empty", g, 32'(empty_v[g]), 32'(q.size() == 0));
      checkOutput("overflow", g, 32'(ovf_v[g]), 32'(m_ovf));
      checkOutput("is_transmitting", g, 32'(busy_v[g]), 32'(cyc < free_at));
      if (cyc >= free_at) checkOutput("tx_idle", g, 32'(tx_v[g]), 1);
    end

    // Line monitor: on a start bit, take the next expected frame and check the
    // start time plus every slot (level and stability for its whole duration).
    initial begin : mon
      frame_t     f;
      logic [7:0] got;
      logic       bitv;
      logic       stable;
      logic       expv;
      int         len;
      bit         aborted;
      forever begin
        @(negedge clk);
        if (!rst && tx_v[g] == 1'b0) begin
          checkOutput("frame_expected", g, 32'(exp_q.size() > 0), 1);
          if (exp_q.size() == 0) begin
            while (!rst && tx_v[g] == 1'b0) @(negedge clk);
          end else begin
            f = exp_q.pop_front();
            checkOutput("start_cycle", g, cyc, f.start);
            aborted = 1'b0;
            got     = 8'h00;
            for (int s = 0; s < NSLOT && !aborted; s++) begin
              len = (s == NSLOT - 1) ? STP * CPB : CPB;
              if (s == 0) expv = 1'b0;
              else if (s <= 8) expv = f.b[s-1];
              else if (s == NSLOT - 1) expv = 1'b1;
              else expv = (PAR == 1) ? ^f.b : ~^f.b;
              stable = 1'b1;
              bitv   = 1'b0;
              for (int k = 0; k < len; k++) begin
                if (s != 0 || k != 0) begin
                  @(negedge clk);
                  if (rst) begin
                    aborted = 1'b1;
                    break;
                  end
                end
                if (k == 0) bitv = tx_v[g];
                else if (tx_v[g] !== bitv) stable = 1'b0;
              end
              if (!aborted) begin
                checkOutput($sformatf("slot%0d", s), g, 32'({stable, bitv}), 32'({1'b1, expv}));
                if (s >= 1 && s <= 8) got[s-1] = bitv;
              end
            end
            if (!aborted) checkOutput("byte", g, 32'(got), 32'(f.b));
          end
        end
      end
    end

    // Every frame the model scheduled must have appeared on the line.
    always @(posedge fin) checkOutput("frames_pending", g, exp_q.size(), 0);
  end

  // Hard stop in case something stalls outside the bounded waits.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation still running at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    int n;
    logic [7:0] b;
    int gap;

    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // Single frames with long gaps: 0x55 pattern, then 0x07 for the parity lanes.
    applyStimulus(8'h55, 220);
    applyStimulus(8'h07, 220);

    // Six consecutive writes into a 4-deep FIFO: the sixth is dropped.
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h3C, 0);
    applyStimulus(8'hFF, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h81, 0);
    applyStimulus(8'h42, 0);
    waitIdle(3000);

    // Reset in the middle of data bit 3 of 0xF0, with two more bytes queued.
    applyStimulus(8'hF0, 0);
    applyStimulus(8'h11, 0);
    applyStimulus(8'h22, 0);
    repeat (68) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_tx", 0, 32'(tx_v), 32'h7);
    checkOutput("rst_busy", 0, 32'(busy_v), 32'h0);
    checkOutput("rst_empty", 0, 32'(empty_v), 32'h7);
    checkOutput("rst_count", 0, 32'(cnt_v[0]), 32'h0);
    checkOutput("rst_overflow", 0, 32'(ovf_v), 32'h0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    applyStimulus(8'h0F, 0);
    waitIdle(3000);

    // Two 0x00 bytes back to back.
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0);
    waitIdle(3000);

    // Stream 0x01..0x0A, writing only while no lane reports full.
    for (int i = 1; i <= 10; i++) begin
      n = 0;
      while (full_v != 3'b000 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      applyStimulus(8'(i), 0);
    end
    waitIdle(5000);

    // Random bytes with a mix of short and long gaps, overflow allowed.
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 3) == 0) gap = $urandom_range(50, 250);
      else gap = $urandom_range(0, 6);
      applyStimulus(b, gap);
    end
    waitIdle(10000);

    fin = 1'b1;
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
